// File: rtl/uart_frame_receiver.sv
// UART 8N1 receive path: deserialises bytes from UART_RX and writes a frame of
// RAM_SIZE bytes into RAM through a one-cycle write strobe, then raises ready.
`timescale 1ns/1ps
module uart_frame_receiver #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 115200,
   parameter int RAM_SIZE  = 28,
   parameter int ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 UART_RX,
   input  logic                 start,
   output logic [ADDR_BITS-1:0] addr,
   output logic                 writeEnable,
   output logic [7:0]           dataOut,
   output logic                 ready,
   output logic                 frameError,
   output logic [2:0]           state_dbg
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_BITS     = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_BITS-1:0]  BIT_LAST  = CNT_BITS'(CLKS_PER_BIT - 1);
   localparam logic [CNT_BITS-1:0]  HALF_LAST = CNT_BITS'(HALF_BIT - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(RAM_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_WRITE = 3'd5
   } state_t;

   state_t              state;
   logic                rx_meta;
   logic                rx_s;
   logic [CNT_BITS-1:0] baud_cnt;
   logic [2:0]          bit_idx;
   logic [7:0]          shift_reg;
   logic                need_idle;

   assign state_dbg = state;

   // Write port: writeEnable is a one-cycle valid with no back-pressure (the RAM
   // always accepts); addr and dataOut are meaningful only while it is high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         baud_cnt    <= '0;
         bit_idx     <= '0;
         shift_reg   <= '0;
         need_idle   <= 1'b0;
         addr        <= '0;
         writeEnable <= 1'b0;
         dataOut     <= '0;
         ready       <= 1'b1;
         frameError  <= 1'b0;
      end else begin
         rx_meta     <= UART_RX;
         rx_s        <= rx_meta;
         writeEnable <= 1'b0;
         case (state)
            S_IDLE: begin
               ready <= 1'b1;
               if (start) begin
                  addr       <= '0;
                  frameError <= 1'b0;
                  ready      <= 1'b0;
                  need_idle  <= 1'b0;
                  state      <= S_ARMED;
               end
            end
            S_ARMED: begin
               // After a bad stop bit the line may still be low (break), so wait
               // for it to return high before looking for the next start edge.
               if (need_idle) begin
                  if (rx_s) need_idle <= 1'b0;
               end else if (!rx_s) begin
                  baud_cnt <= '0;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  if (!rx_s) begin
                     bit_idx <= '0;
                     state   <= S_DATA;
                  end else begin
                     state <= S_ARMED;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt  <= '0;
                  shift_reg <= {rx_s, shift_reg[7:1]};
                  if (bit_idx == 3'd7) state <= S_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_cnt == BIT_LAST) begin
                  baud_cnt <= '0;
                  if (rx_s) begin
                     writeEnable <= 1'b1;
                     dataOut     <= shift_reg;
                     state       <= S_WRITE;
                  end else begin
                     frameError <= 1'b1;
                     need_idle  <= 1'b1;
                     state      <= S_ARMED;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               if (addr == ADDR_LAST) begin
                  ready <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  addr  <= addr + 1'b1;
                  state <= S_ARMED;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Receive side of the UART link: deserialises 8N1 bytes on UART_RX and writes them into a RAM of RAM_SIZE bytes through an addr/writeEnable/data write port.
- Armed by a start pulse.
- Raises ready once RAM_SIZE good bytes are stored, so the processing or transmit side can consume the frame.
- Sits between the board RX pin and the image RAM.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (434 at defaults)
RAM_SIZE, 28, bytes per frame
ADDR_BITS, 5, RAM address width; 2^ADDR_BITS >= RAM_SIZE

Ports:
clk  input  1  system clock (CLOCK_50)
reset  input  1  asynchronous, active-low reset (KEY[0])
UART_RX  input  1  serial input, idle high, asynchronous to clk
start  input  1  one-cycle pulse; arms capture of a new frame
addr  output  ADDR_BITS  RAM write address
writeEnable  output  1  one-cycle RAM write strobe
dataOut  output  8  byte to write; valid while writeEnable=1
ready  output  1  1 = idle/frame complete; 0 = capture in progress
frameError  output  1  sticky: at least one stop bit was sampled low in this frame

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, addr=0, writeEnable=0, dataOut=0, ready=1, frameError=0, bit and baud counters 0, RX synchroniser flops=1.
- UART_RX passes through a 2-flop synchroniser (2-cycle latency). All sampling uses the synchronised value rx_s.
- IDLE: ready=1.
  - start=1 -> addr=0, frameError=0, ready=0, go ARMED.
  - start while not in IDLE is ignored.
- ARMED: wait for rx_s=0 (start edge), then clear the baud counter and go START.
- START: count CLKS_PER_BIT/2 cycles, then sample rx_s.
  - rx_s=0 -> clear counter, bit index 0, go DATA.
  - rx_s=1 -> glitch; return to ARMED with no write and no error.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After the 8th sample go STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s=1 -> go WRITE.
  - rx_s=0 -> frameError=1 (sticky); byte discarded, no write, addr unchanged; go ARMED.
- WRITE (one cycle): writeEnable=1, dataOut=byte, addr=current slot.
  - addr==RAM_SIZE-1 -> next cycle go IDLE with ready=1; addr holds the last value.
  - Otherwise addr increments next cycle; go ARMED.
- Throughput: the FSM returns to ARMED within 1 cycle of the mid-stop sample, so back-to-back bytes with a single stop bit are never lost.
- dataOut holds its last value after the write; writeEnable is never high for more than 1 cycle.
- Sample point: mid-bit, ±1 clk. The total bit-time error from truncating CLKS_PER_BIT is accepted.
- Reset mid-byte or mid-frame: the partial byte is dropped and the reset values above apply immediately. No write is emitted after reset deasserts until a new start.
- start arriving in the same cycle as the final write: ignored; the FSM is not in IDLE.
- UART_RX held low (break) while ARMED: reads as a byte of 0x00 with stop=0 -> frameError=1, then re-arms only after rx_s returns to 1.

Test Plan (sim params: CLK_FREQ=16, BAUD=1 -> 16 clk/bit; RAM_SIZE=4, ADDR_BITS=2):
1. Reset, then start pulse, then send bytes 0xA5, 0x3C, 0xFF, 0x00 back-to-back.
   - Exactly 4 writeEnable pulses at addr 0,1,2,3 with dataOut A5, 3C, FF, 00.
   - ready falls 1 cycle after start and rises 1 cycle after the 4th write.
   - frameError=0.
2. While ARMED, drive a 4-clk low glitch on UART_RX -> no write, addr stays 0, frameError=0. A following byte 0x55 writes to addr 0.
3. Send 0x81 with stop bit forced low, then a good 0x42.
   - frameError=1, no write for 0x81.
   - 0x42 written at addr 0.
   - frameError stays 1 until the next start pulse clears it.
4. Assert reset for 3 cycles mid-way through the 2nd byte.
   - All outputs return to reset values at once.
   - Idle line afterwards produces no writes.
   - A new start then captures from addr 0.
5. Pulse start while capturing (after byte 1), then complete the frame -> the second start has no effect; addr sequence is 0..3 uninterrupted.
6. Bit timing check with defaults (CLKS_PER_BIT=434): send 0x96 at a line rate of 115200 ±2% -> byte received correctly at both extremes.
